cache_flush_wb: RTL and testbench
=================================

Name: cache_flush_wb

Overview:
- Parametrised N-way set-associative write-back, write-allocate cache. Controller and storage are in one block.
- Sits between the CPU-side line adapter (256-bit line interface) and the physical-memory arbiter.
- Generalises our fixed 4-way datapath+control pair:
  - ways and sets are configurable
  - fills go to an invalid way before PLRU eviction
  - a flush/invalidate walk writes back all dirty lines
  - saturating hit/miss counters for perf runs

Parameters:
s_word, 256, line/word width in bits (power of two, >=64)
s_index, 4, set index bits; num_sets = 2**s_index
s_wayidx, 2, way index bits (>=1); num_ways = 2**s_wayidx
s_cnt, 32, perf counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_address  in  32  CPU line address; offset bits ignored
mem_read  in  1  read request, held until mem_resp
mem_write  in  1  write request, held until mem_resp
mem_byte_enable  in  s_word/8  write byte mask
mem_wdata  in  s_word  write data
mem_rdata  out  s_word  read data, valid while mem_resp=1
mem_resp  out  1  one-cycle completion pulse
pmem_address  out  32  {tag,index,0} line address
pmem_read  out  1  fill request, held until pmem_resp
pmem_write  out  1  writeback request, held until pmem_resp
pmem_wdata  out  s_word  writeback data
pmem_rdata  in  s_word  fill data, valid with pmem_resp
pmem_resp  in  1  memory completion
flush_req  in  1  start flush (level, sampled in IDLE)
flush_inv  in  1  invalidate lines during flush (sampled with flush_req)
flush_done  out  1  one-cycle pulse at flush end
hit_count  out  s_cnt  saturating CPU hit count
miss_count  out  s_cnt  saturating CPU miss count

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset effects:
  - all valid and dirty bits = 0; PLRU bits = 0; counters = 0; state IDLE.
  - mem_resp, pmem_read, pmem_write, flush_done = 0.
  - Data and tag contents are don't-care.
  - Reset mid-transaction aborts it. pmem_read/pmem_write are low from the cycle after the rst edge, and no line is written.
- Storage: flops. Tag width = 32 - s_index - log2(s_word/8).
- States: IDLE, RESP, WB, FILL, FL_SCAN, FL_WB, FL_DONE.
- IDLE, request present (mem_read|mem_write):
  - Tag compare against all valid ways of addr_index.
  - Hit: go to RESP. At that edge, a write merges mem_wdata under mem_byte_enable and sets dirty. PLRU is marked MRU for the hit way. hit_count += 1.
  - Miss: choose victim.
    - Lowest-index invalid way if any, else the tree-PLRU victim.
    - Victim valid&dirty -> WB, else -> FILL.
    - miss_count += 1, counted once per request.
  - Both mem_read and mem_write high is illegal; write takes precedence.
- RESP: mem_resp=1 for exactly one cycle; mem_rdata = hit way line (post-write value for writes). Next state IDLE. Hit latency = 1 cycle after request sampled; throughput is one access per 2 cycles.
- WB:
  - pmem_write=1, pmem_address={victim tag,index,0}, pmem_wdata = victim line.
  - On pmem_resp: clear victim dirty, go to FILL.
- FILL:
  - pmem_read=1, pmem_address={addr tag,index,0}.
  - On pmem_resp: write pmem_rdata to victim, load tag, valid=1, dirty=0, go to IDLE.
  - IDLE re-evaluates, hits, and counts one hit.
  - Clean miss latency = pmem latency + 2 cycles to mem_resp.
- pmem_read and pmem_write are never both high.
- PLRU: binary tree, num_ways-1 bits per set. Updated on every hit and on every fill; the accessed way becomes MRU. The victim is the way pointed to by walking the tree.
- Flush:
  - Accepted in IDLE only when flush_req=1 and no mem request; a pending CPU request wins. flush_inv is latched at that point.
  - Set counter s and way counter w start at 0.
  - FL_SCAN, one line per cycle:
    - If valid&dirty: go to FL_WB, with writeback of (s,w) as in WB. On pmem_resp clear dirty; if inv, clear valid; return to FL_SCAN, advancing (w, then s).
    - Else: if inv, clear valid; advance.
  - After (num_sets-1, num_ways-1): go to FL_DONE. flush_done=1 for one cycle, then IDLE.
  - Flush does not touch PLRU or counters. CPU requests arriving during flush wait (no mem_resp).
  - Clean cache, no inv: flush_done is asserted num_sets*num_ways+1 cycles after acceptance.
- Counters saturate at all-ones; they do not wrap.

Test Plan:
- Defaults, after reset: read 0x0000_0100 -> pmem_read with pmem_address=0x0000_0100. pmem_resp after 5 cycles with line A -> mem_resp 2 cycles later, mem_rdata=A. miss_count=1, hit_count=1.
- Write 0x0000_0100 with mem_byte_enable=0x0000_000F, wdata byte0..3 = 0xDEADBEEF -> mem_resp exactly 1 cycle after request. Subsequent read returns A with bytes 0..3 replaced. No pmem activity.
- Fill 5 distinct tags into set 8, writing way of tag1 first -> 5th miss selects the PLRU victim (not an invalid way). If that victim is dirty: pmem_write of the old tag address precedes pmem_read; otherwise pmem_read only.
- Flush with 2 dirty lines, flush_inv=1 -> exactly 2 pmem_write transactions in set/way order, then flush_done pulse. Next read of either address misses. Clean cache -> flush_done 65 cycles after acceptance.
- Assert rst while pmem_write high in WB -> pmem_write=0 next cycle; all reads then miss; counters 0.
- Force hit_count to all-ones (s_cnt=4 build, 16 hits) -> stays 0xF.

Source files
------------

// File: rtl/cache_flush_wb_if.sv
// cache_flush_wb_if: CPU line port and physical-memory port of the flushable write-back cache
interface cache_flush_wb_if #(
    parameter int s_word = 256
);
    logic [31:0]         mem_address;
    logic                mem_read;
    logic                mem_write;
    logic [s_word/8-1:0] mem_byte_enable;
    logic [s_word-1:0]   mem_wdata;
    logic [s_word-1:0]   mem_rdata;
    logic                mem_resp;
    logic [31:0]         pmem_address;
    logic                pmem_read;
    logic                pmem_write;
    logic [s_word-1:0]   pmem_wdata;
    logic [s_word-1:0]   pmem_rdata;
    logic                pmem_resp;
    modport slave (
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata, pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
    );
    modport master (
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata, pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
    );
endinterface

// File: rtl/cache_flush_wb.sv
// cache_flush_wb: N-way write-back/write-allocate cache with tree-PLRU, flush/invalidate walk and perf counters
module cache_flush_wb #(
    parameter int s_word   = 256,
    parameter int s_index  = 4,
    parameter int s_wayidx = 2,
    parameter int s_cnt    = 32
) (
    input  logic             clk,
    input  logic             rst,
    cache_flush_wb_if.slave  bus,
    input  logic             flush_req_i,
    input  logic             flush_inv_i,
    output logic             flush_done_o,
    output logic [s_cnt-1:0] hit_count_o,
    output logic [s_cnt-1:0] miss_count_o
);
    localparam int num_sets = 2 ** s_index;
    localparam int num_ways = 2 ** s_wayidx;
    localparam int s_be     = s_word / 8;
    localparam int s_off    = $clog2(s_be);
    localparam int s_tag    = 32 - s_index - s_off;
    localparam logic [2:0] IDLE = 3'd0, RESP = 3'd1, WB = 3'd2, FILL = 3'd3,
                           FL_SCAN = 3'd4, FL_WB = 3'd5, FL_DONE = 3'd6;

    // Tree bit n (1..num_ways-1) is heap-indexed; bit 0 is never used.
    function automatic logic [s_wayidx-1:0] plru_victim(input logic [num_ways-1:0] t);
        logic [s_wayidx-1:0] v;
        int n;
        v = '0;
        n = 1;
        for (int l = 0; l < s_wayidx; l++) begin
            v[s_wayidx-1-l] = t[s_wayidx'(n)];
            n = 2 * n + int'(t[s_wayidx'(n)]);
        end
        return v;
    endfunction

    function automatic logic [num_ways-1:0] plru_touch(input logic [num_ways-1:0] t,
                                                       input logic [s_wayidx-1:0] w);
        logic b;
        int n;
        n = 1;
        for (int l = 0; l < s_wayidx; l++) begin
            b = w[s_wayidx-1-l];
            t[s_wayidx'(n)] = ~b;
            n = 2 * n + int'(b);
        end
        return t;
    endfunction

    logic [s_word-1:0]   data_q [num_sets][num_ways];
    logic [s_tag-1:0]    tag_q [num_sets][num_ways];
    logic [num_ways-1:0] valid_q [num_sets];
    logic [num_ways-1:0] dirty_q [num_sets];
    logic [num_ways-1:0] plru_q [num_sets];
    logic [2:0]          state_q, state_d;
    logic [s_wayidx-1:0] way_q, way_d;
    logic [s_index-1:0]  fs_q;
    logic [s_wayidx-1:0] fw_q;
    logic                inv_q;
    logic [s_cnt-1:0]    hit_q, miss_q;

    logic [s_tag-1:0]    a_tag;
    logic [s_index-1:0]  a_idx;
    logic                req, hit, has_inv, fl_dirty, fl_last, fl_adv, wr_hit, fill_ok, fl_wb;
    logic [s_wayidx-1:0] hit_way, inv_way, victim;
    logic [s_word-1:0]   merged;

    assign a_tag    = bus.mem_address[31 -: s_tag];
    assign a_idx    = bus.mem_address[s_off +: s_index];
    assign req      = bus.mem_read | bus.mem_write;
    assign fl_dirty = valid_q[fs_q][fw_q] & dirty_q[fs_q][fw_q];
    assign fl_last  = &{fs_q, fw_q};
    assign fl_adv   = (state_q == FL_SCAN && !fl_dirty) || (state_q == FL_WB && bus.pmem_resp);
    assign wr_hit   = state_q == IDLE && req && hit && bus.mem_write;
    assign fill_ok  = state_q == FILL && bus.pmem_resp;
    assign fl_wb    = state_q == FL_WB;

    always_comb begin
        hit = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = num_ways - 1; w >= 0; w--) begin
            if (valid_q[a_idx][w] && tag_q[a_idx][w] == a_tag) begin
                hit = 1'b1;
                hit_way = s_wayidx'(w);
            end
            if (!valid_q[a_idx][w]) begin
                has_inv = 1'b1;
                inv_way = s_wayidx'(w);
            end
        end
        victim = has_inv ? inv_way : plru_victim(plru_q[a_idx]);
        merged = data_q[a_idx][hit_way];
        for (int b = 0; b < s_be; b++)
            if (bus.mem_byte_enable[b]) merged[8*b +: 8] = bus.mem_wdata[8*b +: 8];
    end

    always_comb begin
        state_d = state_q;
        way_d = way_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    way_d = hit ? hit_way : victim;
                    state_d = hit ? RESP : (valid_q[a_idx][victim] && dirty_q[a_idx][victim]) ? WB : FILL;
                end else if (flush_req_i) state_d = FL_SCAN;
            end
            RESP:    state_d = IDLE;
            WB:      state_d = bus.pmem_resp ? FILL : WB;
            FILL:    state_d = bus.pmem_resp ? IDLE : FILL;
            FL_SCAN: state_d = fl_dirty ? FL_WB : fl_last ? FL_DONE : FL_SCAN;
            FL_WB:   state_d = !bus.pmem_resp ? FL_WB : fl_last ? FL_DONE : FL_SCAN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            way_q <= '0;
            fs_q <= '0;
            fw_q <= '0;
            inv_q <= 1'b0;
            hit_q <= '0;
            miss_q <= '0;
            for (int s = 0; s < num_sets; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s] <= '0;
            end
        end else begin
            state_q <= state_d;
            way_q <= way_d;
            if (state_q == IDLE && req && hit) begin
                hit_q <= hit_q + s_cnt'(~&hit_q);
                plru_q[a_idx] <= plru_touch(plru_q[a_idx], hit_way);
                if (bus.mem_write) dirty_q[a_idx][hit_way] <= 1'b1;
            end
            if (state_q == IDLE && req && !hit) miss_q <= miss_q + s_cnt'(~&miss_q);
            if (state_q == IDLE && !req && flush_req_i) begin
                inv_q <= flush_inv_i;
                fs_q <= '0;
                fw_q <= '0;
            end
            if (state_q == WB && bus.pmem_resp) dirty_q[a_idx][way_q] <= 1'b0;
            if (fill_ok) begin
                valid_q[a_idx][way_q] <= 1'b1;
                dirty_q[a_idx][way_q] <= 1'b0;
                plru_q[a_idx] <= plru_touch(plru_q[a_idx], way_q);
            end
            if (fl_wb && bus.pmem_resp) dirty_q[fs_q][fw_q] <= 1'b0;
            if (fl_adv) begin
                if (inv_q) valid_q[fs_q][fw_q] <= 1'b0;
                {fs_q, fw_q} <= {fs_q, fw_q} + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_hit) data_q[a_idx][hit_way] <= merged;
        if (!rst && fill_ok) begin
            data_q[a_idx][way_q] <= bus.pmem_rdata;
            tag_q[a_idx][way_q] <= a_tag;
        end
    end

    assign bus.mem_resp     = state_q == RESP;
    assign bus.mem_rdata    = data_q[a_idx][way_q];
    assign bus.pmem_read    = state_q == FILL;
    assign bus.pmem_write   = state_q == WB || fl_wb;
    assign bus.pmem_address = fl_wb ? {tag_q[fs_q][fw_q], fs_q, {s_off{1'b0}}}
                            : state_q == WB ? {tag_q[a_idx][way_q], a_idx, {s_off{1'b0}}}
                            : {a_tag, a_idx, {s_off{1'b0}}};
    assign bus.pmem_wdata   = fl_wb ? data_q[fs_q][fw_q] : data_q[a_idx][way_q];
    assign flush_done_o     = state_q == FL_DONE;
    assign hit_count_o      = hit_q;
    assign miss_count_o     = miss_q;
endmodule

// File: tb/tb_cache_flush_wb.sv
// tb_cache_flush_wb: directed + randomized checks of cache_flush_wb against a timestamp-LRU-tree reference model
module tb_cache_flush_wb;
    localparam int SW = 256, CW = 4, NS = 16, NW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush_req = 1'b0, flush_inv = 1'b0, flush_done;
    logic [CW-1:0] hit_count, miss_count;
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    cache_flush_wb_if #(.s_word(SW)) bus();
    cache_flush_wb #(.s_word(SW), .s_index(4), .s_wayidx(2), .s_cnt(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus), .flush_req_i(flush_req), .flush_inv_i(flush_inv),
        .flush_done_o(flush_done), .hit_count_o(hit_count), .miss_count_o(miss_count)
    );

    // Reference state: lines per set/way, last-access times, and the backing memory.
    logic          mv [NS][NW];
    logic          md [NS][NW];
    logic [22:0]   mt [NS][NW];
    logic [255:0]  mdat [NS][NW];
    int            mts [NS][NW];
    int            mtime;
    logic [CW-1:0] mhit, mmiss;
    logic [255:0]  pm [logic [31:0]];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [255:0] pm_get(input logic [31:0] a);
        if (!pm.exists(a)) pm[a] = rand_line();
        return pm[a];
    endfunction

    function automatic logic [CW-1:0] sat(input logic [CW-1:0] x);
        return (x == {CW{1'b1}}) ? x : x + 1'b1;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) begin
                mv[s][w] = 1'b0;
                md[s][w] = 1'b0;
                mts[s][w] = 0;
            end
        mhit = '0;
        mmiss = '0;
        mtime = 0;
    endtask

    // Tree-PLRU equals: at each split, go to the half whose latest access is older.
    function automatic int m_victim(input int s);
        int lo, n, ml, mr;
        for (int w = 0; w < NW; w++) if (!mv[s][w]) return w;
        lo = 0;
        n = NW;
        while (n > 1) begin
            n = n / 2;
            ml = 0;
            mr = 0;
            for (int i = 0; i < n; i++) begin
                if (mts[s][lo+i] > ml) ml = mts[s][lo+i];
                if (mts[s][lo+n+i] > mr) mr = mts[s][lo+n+i];
            end
            if (mr < ml) lo += n;
        end
        return lo;
    endfunction

    task automatic model_access(input logic [31:0] a, input logic wr, input logic [31:0] be,
                                input logic [255:0] wd, output logic ewb, output logic [31:0] ewa,
                                output logic [255:0] ewd, output logic efill,
                                output logic [31:0] efa, output logic [255:0] erd);
        int s, w;
        logic [22:0] t;
        s = int'(a[8:5]);
        t = a[31:9];
        w = -1;
        ewb = 1'b0;
        efill = 1'b0;
        ewa = '0;
        ewd = '0;
        efa = {a[31:5], 5'b0};
        for (int i = 0; i < NW; i++) if (mv[s][i] && mt[s][i] == t) w = i;
        if (w < 0) begin
            mmiss = sat(mmiss);
            w = m_victim(s);
            efill = 1'b1;
            if (mv[s][w] && md[s][w]) begin
                ewb = 1'b1;
                ewa = {mt[s][w], a[8:5], 5'b0};
                ewd = mdat[s][w];
                pm[ewa] = ewd;
            end
            mdat[s][w] = pm_get(efa);
            mt[s][w] = t;
            mv[s][w] = 1'b1;
            md[s][w] = 1'b0;
            mtime++;
            mts[s][w] = mtime;
        end
        mhit = sat(mhit);
        if (wr) begin
            for (int b = 0; b < 32; b++) if (be[b]) mdat[s][w][8*b +: 8] = wd[8*b +: 8];
            md[s][w] = 1'b1;
        end
        mtime++;
        mts[s][w] = mtime;
        erd = mdat[s][w];
    endtask

    // Memory side: answer a held pmem request after lat waiting cycles, one-cycle pmem_resp.
    task automatic pmem_tick(input int lat, inout int wc, output logic wdn, output logic rdn,
                             output logic [31:0] pa, output logic [255:0] pd);
        wdn = 1'b0;
        rdn = 1'b0;
        pa = bus.pmem_address;
        pd = bus.pmem_wdata;
        chk("pmem_excl", bus.pmem_read & bus.pmem_write, 1'b0);
        if (bus.pmem_resp) bus.pmem_resp = 1'b0;
        else if (bus.pmem_read || bus.pmem_write) begin
            if (wc < lat) wc++;
            else begin
                wc = 0;
                bus.pmem_resp = 1'b1;
                wdn = bus.pmem_write;
                rdn = bus.pmem_read;
                if (bus.pmem_read) bus.pmem_rdata = pm_get(bus.pmem_address);
            end
        end
    endtask

    task automatic access(input logic [31:0] a, input logic wr, input logic [31:0] be,
                          input logic [255:0] wd, input int lat, input int exp_cyc);
        logic ewb, efill, wdn, rdn, done;
        logic [31:0] ewa, efa, pa, wa, fa;
        logic [255:0] ewd, erd, pd, wdat, rd;
        int nwb, nfill, wc, cyc, wb_before;
        model_access(a, wr, be, wd, ewb, ewa, ewd, efill, efa, erd);
        bus.mem_address = a;
        bus.mem_read = !wr;
        bus.mem_write = wr;
        bus.mem_byte_enable = be;
        bus.mem_wdata = wd;
        nwb = 0; nfill = 0; wc = 0; cyc = 0; wb_before = 0; done = 1'b0;
        wa = '0; fa = '0; wdat = '0; rd = '0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            pmem_tick(lat, wc, wdn, rdn, pa, pd);
            if (wdn) begin
                nwb++;
                wa = pa;
                wdat = pd;
            end
            if (rdn) begin
                nfill++;
                fa = pa;
                wb_before = nwb;
            end
            if (bus.mem_resp) begin
                done = 1'b1;
                rd = bus.mem_rdata;
            end
        end
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        chk("resp_seen", done, 1'b1);
        chk("wb_count", nwb, ewb);
        chk("fill_count", nfill, efill);
        if (ewb) begin
            chk("wb_addr", wa, ewa);
            chk("wb_data", wdat, ewd);
        end
        if (efill) begin
            chk("fill_addr", fa, efa);
            chk("wb_before_fill", wb_before, ewb);
        end
        chk("rdata", rd, erd);
        if (exp_cyc > 0) chk("latency", cyc, exp_cyc);
        chk("hit_count", hit_count, mhit);
        chk("miss_count", miss_count, mmiss);
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        chk("resp_pulse", bus.mem_resp, 1'b0);
    endtask

    task automatic do_flush(input logic inv, input int lat, input int exp_cyc);
        logic [31:0] qa[$];
        logic [255:0] qd[$];
        logic [31:0] a, pa;
        logic [255:0] pd;
        logic wdn, rdn, done;
        int cyc, nwb, nrd, wc;
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) begin
                if (mv[s][w] && md[s][w]) begin
                    a = {mt[s][w], 4'(s), 5'b0};
                    qa.push_back(a);
                    qd.push_back(mdat[s][w]);
                    pm[a] = mdat[s][w];
                    md[s][w] = 1'b0;
                end
                if (inv) mv[s][w] = 1'b0;
            end
        flush_req = 1'b1;
        flush_inv = inv;
        cyc = 0; nwb = 0; nrd = 0; wc = 0; done = 1'b0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                flush_req = 1'b0;
                flush_inv = 1'b0;
            end
            pmem_tick(lat, wc, wdn, rdn, pa, pd);
            if (wdn) begin
                if (nwb < qa.size()) begin
                    chk("fl_wb_addr", pa, qa[nwb]);
                    chk("fl_wb_data", pd, qd[nwb]);
                end
                nwb++;
            end
            if (rdn) nrd++;
            if (flush_done) done = 1'b1;
        end
        chk("flush_done_seen", done, 1'b1);
        chk("fl_wb_count", nwb, qa.size());
        chk("fl_read_count", nrd, 0);
        if (exp_cyc > 0) chk("flush_latency", cyc, exp_cyc);
        chk("fl_hit_count", hit_count, mhit);
        chk("fl_miss_count", miss_count, mmiss);
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        chk("flush_done_pulse", flush_done, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        bus.pmem_resp = 1'b0;
        flush_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [31:0] set_addr(input int t, input int s);
        return {23'(t), 4'(s), 5'b0};
    endfunction

    initial begin
        logic [31:0] a;
        logic [255:0] wd;
        int cyc;
        bus.mem_address = '0;
        bus.mem_byte_enable = '0;
        bus.mem_wdata = '0;
        bus.pmem_rdata = '0;
        do_reset();
        chk("rst_hit", hit_count, 0);
        chk("rst_miss", miss_count, 0);
        chk("rst_mem_resp", bus.mem_resp, 0);
        chk("rst_pmem_read", bus.pmem_read, 0);
        chk("rst_pmem_write", bus.pmem_write, 0);
        chk("rst_flush_done", flush_done, 0);

        access(32'h0000_0100, 1'b0, '0, '0, 5, 8);
        chk("first_miss", miss_count, 1);
        chk("first_hit", hit_count, 1);
        wd = '0;
        wd[31:0] = 32'hDEAD_BEEF;
        access(32'h0000_0100, 1'b1, 32'h0000_000F, wd, 0, 1);
        access(32'h0000_0100, 1'b0, '0, '0, 0, 1);

        do_reset();
        access(set_addr(1, 8), 1'b1, 32'hFFFF_FFFF, rand_line(), 1, -1);
        for (int t = 2; t <= 5; t++) access(set_addr(t, 8), 1'b0, '0, '0, 2, -1);
        access(set_addr(1, 8), 1'b0, '0, '0, 0, -1);

        do_reset();
        access(set_addr(3, 2), 1'b1, 32'h00FF_00FF, rand_line(), 0, -1);
        access(set_addr(4, 5), 1'b1, 32'hF0F0_0001, rand_line(), 0, -1);
        do_flush(1'b1, 2, -1);
        access(set_addr(3, 2), 1'b0, '0, '0, 1, -1);
        access(set_addr(4, 5), 1'b0, '0, '0, 1, -1);
        do_flush(1'b0, 0, NS * NW + 1);

        do_reset();
        for (int i = 0; i < 260; i++) begin
            a = {23'($urandom_range(0, 5)), 4'($urandom_range(0, 3)), 5'($urandom())};
            access(a, 1'($urandom_range(0, 1)), $urandom(), rand_line(), $urandom_range(0, 3), -1);
            if (i == 100) do_flush(1'b0, 1, -1);
            if (i == 200) do_flush(1'b1, 0, -1);
        end

        do_reset();
        for (int t = 1; t <= 4; t++) access(set_addr(t, 3), 1'b1, 32'hFFFF_FFFF, rand_line(), 0, -1);
        bus.mem_address = set_addr(9, 3);
        bus.mem_write = 1'b1;
        bus.mem_byte_enable = '1;
        cyc = 0;
        while (!bus.pmem_write && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("wb_reached", bus.pmem_write, 1'b1);
        rst = 1'b1;
        bus.mem_write = 1'b0;
        @(negedge clk);
        chk("abort_pmem_write", bus.pmem_write, 1'b0);
        chk("abort_pmem_read", bus.pmem_read, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("abort_hit", hit_count, mhit);
        chk("abort_miss", miss_count, mmiss);
        for (int t = 1; t <= 4; t++) access(set_addr(t, 3), 1'b0, '0, '0, 0, -1);

        do_reset();
        for (int i = 0; i < 17; i++) access(32'h0000_0200, 1'b0, '0, '0, 0, -1);
        chk("hit_saturated", hit_count, 4'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
